// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified instruction/data memory port arbiter.
// Contents: FSM state encoding (IDLE/ACCESS), access owner encoding (FETCH/DATA),
//           default NOP instruction and the word-access funct3 used for fetches.
package mem_port_arbiter_pkg;

  // The arbiter is either free to grant (IDLE) or sequencing one memory access.
  // The response pulse overlaps the following IDLE cycle, so no RESP state exists.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // Which requester owns the access currently in flight.
  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  // add x0,x0,x0 -- what the IF stage sees whenever no fetch completes.
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0033;

  // Fetches are always full 32-bit word reads.
  localparam logic [2:0] FUNCT3_LW = 3'b010;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared instruction/data memory between the IF fetch port and the
// MEM-stage load/store port. Fixed priority: data wins over fetch.
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   if_req/if_addr/if_flush       fetch request (held until if_gnt), squash of in-flight fetch
//   if_gnt/if_rvalid/if_rdata     fetch accept, one-cycle completion pulse, instruction (NOP when idle)
//   d_req/d_we/d_funct3/d_addr/d_wdata   data request fields (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata        data accept, one-cycle completion pulse, load data (0 for stores)
//   mem_re/mem_we/mem_funct3/mem_addr/mem_wdata/mem_rdata   memory interface
//   busy                          an access is in progress
// Timing: grant in cycle T (IDLE), memory driven T+1..T+MEM_LATENCY, rvalid at
// T+MEM_LATENCY+1, which is itself an IDLE cycle able to grant again.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          MEM_LATENCY = 1,
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  // memory
  output logic              mem_re,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  // status
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  owner_t             owner_q;
  logic               we_q;
  logic [2:0]         funct3_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic               flush_pend_q;
  logic               resp_if_q;
  logic               resp_d_q;
  logic [31:0]        rdata_q;

  logic               grant_d;
  logic               grant_f;
  logic               last_cycle;

  // Upper address bits are outside the memory and deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and grant decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    grant_d    = 1'b0;
    grant_f    = 1'b0;
    last_cycle = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Grants are suppressed in the reset cycle so nothing is accepted
        // that the reset is about to discard.
        if (!rst) begin
          if (d_req) begin
            grant_d = 1'b1;
            state_d = ST_ACCESS;
          end else if (if_req) begin
            grant_f = 1'b1;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          last_cycle = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Access latch, latency counter, response capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      owner_q      <= OWN_FETCH;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      flush_pend_q <= 1'b0;
      resp_if_q    <= 1'b0;
      resp_d_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      // Response flags are single-cycle pulses.
      resp_if_q <= 1'b0;
      resp_d_q  <= 1'b0;

      if (grant_d || grant_f) begin
        cnt_q        <= CNT_ONE;
        owner_q      <= grant_d ? OWN_DATA : OWN_FETCH;
        we_q         <= grant_d && d_we;
        funct3_q     <= grant_d ? d_funct3 : FUNCT3_LW;
        addr_q       <= grant_d ? d_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
        wdata_q      <= grant_d ? d_wdata : '0;
        flush_pend_q <= 1'b0;
      end else if (state_q == ST_ACCESS) begin
        // A flush seen on any access cycle kills the fetch result; flush is
        // meaningless for data accesses, which always complete.
        if (owner_q == OWN_FETCH && if_flush) begin
          flush_pend_q <= 1'b1;
        end
        if (last_cycle) begin
          cnt_q     <= '0;
          rdata_q   <= we_q ? 32'h0 : mem_rdata;
          resp_if_q <= (owner_q == OWN_FETCH) && !flush_pend_q && !if_flush;
          resp_d_q  <= (owner_q == OWN_DATA);
        end else begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy       = (state_q == ST_ACCESS);
  assign if_gnt     = grant_f;
  assign d_gnt      = grant_d;

  // Memory pins are quiet whenever no access is in progress.
  assign mem_re     = busy && !we_q;
  assign mem_we     = busy && we_q;
  assign mem_funct3 = busy ? funct3_q : 3'b000;
  assign mem_addr   = busy ? addr_q : '0;
  assign mem_wdata  = busy ? wdata_q : 32'h0;

  // A flush arriving in the response cycle itself still squashes the fetch.
  assign if_rvalid  = resp_if_q && !if_flush && !rst;
  assign if_rdata   = if_rvalid ? rdata_q : NOP_INSTR;
  assign d_rvalid   = resp_d_q && !rst;
  assign d_rdata    = d_rvalid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam logic [31:0] NOP = 32'h0000_0033;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // lane 0: MEM_LATENCY=1, lane 1: MEM_LATENCY=3
  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic        if_flush  [2];
  logic        if_gnt    [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata  [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [2:0]  d_funct3  [2];
  logic [31:0] d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic        d_gnt     [2];
  logic        d_rvalid  [2];
  logic [31:0] d_rdata   [2];
  logic        mem_re    [2];
  logic        mem_we    [2];
  logic [2:0]  mem_funct3[2];
  logic [7:0]  mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  logic [31:0] mem [256];

  for (genvar g = 0; g < 2; g++) begin : gen_lane
    assign mem_rdata[g] = mem[mem_addr[g]];
    mem_port_arbiter #(.ADDR_W(8), .MEM_LATENCY((g == 0) ? 1 : 3), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_flush(if_flush[g]),
      .if_gnt(if_gnt[g]), .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_funct3(d_funct3[g]), .d_addr(d_addr[g]),
      .d_wdata(d_wdata[g]), .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .mem_re(mem_re[g]), .mem_we(mem_we[g]), .mem_funct3(mem_funct3[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .busy(busy[g])
    );
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input int ln, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s lane%0d: got %h expected %h at %0t", nm, ln, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: one access occupies the memory for LAT cycles after its
  // grant; its result is reported the cycle after that. Checked every cycle.
  // ---------------------------------------------------------------------------
  bit          m_busy [2];
  int          m_left [2];
  bit          m_own  [2];   // 1 = data
  bit          m_we   [2];
  logic [2:0]  m_f3   [2];
  logic [7:0]  m_addr [2];
  logic [31:0] m_wd   [2];
  bit          m_fl   [2];
  bit          r_pend [2];
  bit          r_own  [2];
  bit          r_we   [2];
  bit          r_fl   [2];
  logic [31:0] r_data [2];
  logic        e_dg, e_ig, e_iv, e_dv;
  logic [31:0] e_ir, e_dr;

  always @(negedge clk) begin
    if (rst) begin
      for (int l = 0; l < 2; l++) begin
        m_busy[l] = 0;
        r_pend[l] = 0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        e_dg = !m_busy[l] && d_req[l];
        e_ig = !m_busy[l] && !d_req[l] && if_req[l];
        e_iv = r_pend[l] && !r_own[l] && !r_fl[l] && !if_flush[l];
        e_ir = e_iv ? r_data[l] : NOP;
        e_dv = r_pend[l] && r_own[l];
        e_dr = (e_dv && !r_we[l]) ? r_data[l] : 32'h0;
        chk("mdl_d_gnt", l, d_gnt[l], e_dg);
        chk("mdl_if_gnt", l, if_gnt[l], e_ig);
        chk("mdl_busy", l, busy[l], m_busy[l]);
        chk("mdl_mem_re", l, mem_re[l], m_busy[l] && !m_we[l]);
        chk("mdl_mem_we", l, mem_we[l], m_busy[l] && m_we[l]);
        chk("mdl_mem_addr", l, mem_addr[l], m_busy[l] ? m_addr[l] : 8'h0);
        chk("mdl_mem_f3", l, mem_funct3[l], m_busy[l] ? m_f3[l] : 3'b0);
        if (!m_busy[l] || m_we[l])
          chk("mdl_mem_wdata", l, mem_wdata[l], m_busy[l] ? m_wd[l] : 32'h0);
        chk("mdl_if_rvalid", l, if_rvalid[l], e_iv);
        chk("mdl_if_rdata", l, if_rdata[l], e_ir);
        chk("mdl_d_rvalid", l, d_rvalid[l], e_dv);
        chk("mdl_d_rdata", l, d_rdata[l], e_dr);
        // advance one cycle
        r_pend[l] = 0;
        if (m_busy[l]) begin
          if (if_flush[l] && !m_own[l]) m_fl[l] = 1;
          m_left[l]--;
          if (m_left[l] == 0) begin
            r_pend[l] = 1;
            r_own[l]  = m_own[l];
            r_we[l]   = m_we[l];
            r_fl[l]   = m_fl[l];
            r_data[l] = mem[m_addr[l]];
            m_busy[l] = 0;
          end
        end else if (e_dg || e_ig) begin
          m_busy[l] = 1;
          m_left[l] = (l == 0) ? 1 : 3;
          m_own[l]  = e_dg;
          m_we[l]   = e_dg && d_we[l];
          m_f3[l]   = e_dg ? d_funct3[l] : 3'b010;
          m_addr[l] = e_dg ? d_addr[l][7:0] : if_addr[l][7:0];
          m_wd[l]   = e_dg ? d_wdata[l] : 32'h0;
          m_fl[l]   = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int ndg, nig, nboth;
  bit gi [2];
  bit gd [2];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 32'h0050_0093;
    mem[8'h14] = 32'h00A0_0113;
    mem[8'h40] = 32'h1234_5678;
    mem[8'h80] = 32'hCAFE_F00D;
    for (int l = 0; l < 2; l++) begin
      if_req[l] = 0; if_addr[l] = 0; if_flush[l] = 0;
      d_req[l] = 0; d_we[l] = 0; d_funct3[l] = 0; d_addr[l] = 0; d_wdata[l] = 0;
    end
    repeat (3) cyc();
    rst = 0;
    cyc();

    // reset state
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      chk("rst_busy", l, busy[l], 0);
      chk("rst_if_rdata", l, if_rdata[l], NOP);
      chk("rst_mem_re", l, mem_re[l], 0);
      chk("rst_d_rvalid", l, d_rvalid[l], 0);
    end

    // 1: fetch 0x10, LAT=1
    cyc(); if_req[0] = 1; if_addr[0] = 32'h0000_0010;
    @(negedge clk); chk("t1_if_gnt", 0, if_gnt[0], 1); chk("t1_d_gnt", 0, d_gnt[0], 0);
    cyc(); if_req[0] = 0;
    @(negedge clk); chk("t1_mem_re", 0, mem_re[0], 1); chk("t1_mem_addr", 0, mem_addr[0], 32'h10);
    cyc();
    @(negedge clk); chk("t1_if_rvalid", 0, if_rvalid[0], 1); chk("t1_if_rdata", 0, if_rdata[0], 32'h0050_0093);

    // 2: simultaneous load 0x40 and fetch 0x14
    cyc(); d_req[0] = 1; d_we[0] = 0; d_funct3[0] = 3'b010; d_addr[0] = 32'h40;
    if_req[0] = 1; if_addr[0] = 32'h14;
    @(negedge clk); chk("t2_d_gnt", 0, d_gnt[0], 1); chk("t2_if_gnt", 0, if_gnt[0], 0);
    cyc(); d_req[0] = 0;
    @(negedge clk); chk("t2_if_gnt_busy", 0, if_gnt[0], 0);
    cyc();
    @(negedge clk); chk("t2_d_rvalid", 0, d_rvalid[0], 1); chk("t2_d_rdata", 0, d_rdata[0], 32'h1234_5678);
    chk("t2_if_gnt_late", 0, if_gnt[0], 1);
    cyc(); if_req[0] = 0;
    cyc();
    @(negedge clk); chk("t2_if_rdata", 0, if_rdata[0], 32'h00A0_0113);

    // 3: store 0x44
    cyc(); d_req[0] = 1; d_we[0] = 1; d_addr[0] = 32'h44; d_wdata[0] = 32'hDEAD_BEEF;
    @(negedge clk); chk("t3_d_gnt", 0, d_gnt[0], 1);
    cyc(); d_req[0] = 0;
    @(negedge clk); chk("t3_mem_we", 0, mem_we[0], 1); chk("t3_mem_re", 0, mem_re[0], 0);
    chk("t3_mem_addr", 0, mem_addr[0], 32'h44); chk("t3_mem_wdata", 0, mem_wdata[0], 32'hDEAD_BEEF);
    cyc();
    @(negedge clk); chk("t3_d_rvalid", 0, d_rvalid[0], 1); chk("t3_d_rdata", 0, d_rdata[0], 0);
    chk("t3_if_rvalid", 0, if_rvalid[0], 0); chk("t3_mem_we_off", 0, mem_we[0], 0);
    d_we[0] = 0;

    // 4: fetch flushed at T+1
    cyc(); if_req[0] = 1; if_addr[0] = 32'h20;
    @(negedge clk); chk("t4_if_gnt", 0, if_gnt[0], 1);
    cyc(); if_req[0] = 0; if_flush[0] = 1;
    @(negedge clk); chk("t4_busy", 0, busy[0], 1);
    cyc(); if_flush[0] = 0;
    @(negedge clk); chk("t4_if_rvalid", 0, if_rvalid[0], 0); chk("t4_if_rdata", 0, if_rdata[0], NOP);
    chk("t4_busy_drop", 0, busy[0], 0);

    // 5: LAT=3 load 0x80, then the same load cut by reset at T+2
    cyc(); d_req[1] = 1; d_we[1] = 0; d_funct3[1] = 3'b010; d_addr[1] = 32'h80;
    @(negedge clk); chk("t5_d_gnt", 1, d_gnt[1], 1);
    cyc(); d_req[1] = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); chk("t5_mem_re", 1, mem_re[1], 1);
      cyc();
    end
    @(negedge clk); chk("t5_d_rvalid", 1, d_rvalid[1], 1); chk("t5_d_rdata", 1, d_rdata[1], 32'hCAFE_F00D);
    chk("t5_mem_re_off", 1, mem_re[1], 0);
    cyc(); d_req[1] = 1;
    @(negedge clk); chk("t5b_d_gnt", 1, d_gnt[1], 1);
    cyc(); d_req[1] = 0;
    cyc(); rst = 1;
    cyc(); rst = 0;
    @(negedge clk); chk("t5b_busy", 1, busy[1], 0); chk("t5b_mem_re", 1, mem_re[1], 0);
    chk("t5b_d_rvalid", 1, d_rvalid[1], 0); chk("t5b_if_rdata", 1, if_rdata[1], NOP);
    cyc();
    @(negedge clk); chk("t5b_no_late_rvalid", 1, d_rvalid[1], 0);

    // 6: continuous competing requests, LAT=1
    cyc(); d_req[0] = 1; d_addr[0] = 32'h40; if_req[0] = 1; if_addr[0] = 32'h10;
    ndg = 0; nig = 0; nboth = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d_gnt[0]) ndg++;
      if (if_gnt[0]) nig++;
      if (d_gnt[0] && if_gnt[0]) nboth++;
      cyc();
    end
    chk("t6_d_gnts", 0, ndg, 10); chk("t6_if_gnts", 0, nig, 0); chk("t6_double_gnt", 0, nboth, 0);
    d_req[0] = 0; if_req[0] = 0;
    repeat (5) cyc();

    // random traffic on both lanes, with two single-cycle resets
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        gi[l] = if_gnt[l];
        gd[l] = d_gnt[l];
      end
      cyc();
      rst = (n == 700) || (n == 1400);
      for (int l = 0; l < 2; l++) begin
        if (d_req[l] && !gd[l]) begin
          if ($urandom_range(15) == 0) d_req[l] = 0;
        end else begin
          d_req[l]    = ($urandom_range(3) == 0);
          d_we[l]     = 1'($urandom_range(1));
          d_funct3[l] = 3'($urandom_range(7));
          d_addr[l]   = $urandom;
          d_wdata[l]  = $urandom;
        end
        if (if_req[l] && !gi[l]) begin
          if ($urandom_range(15) == 0) if_req[l] = 0;
        end else begin
          if_req[l]  = ($urandom_range(1) == 0);
          if_addr[l] = $urandom;
        end
        if_flush[l] = ($urandom_range(7) == 0);
      end
    end
    rst = 0;
    for (int l = 0; l < 2; l++) begin
      d_req[l] = 0; if_req[l] = 0; if_flush[l] = 0;
    end
    repeat (6) cyc();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
